// File: rtl/nmea_time_parser.sv
// Parses NMEA RMC sentences from a UART byte stream and outputs the UTC time as BCD digits.
// Define NMEA_CHECKSUM_EN to also verify the "*hh" checksum before the time is committed.
module nmea_time_parser #(
  parameter int MAX_LEN = 82
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] sec_1,
  output logic [2:0] sec_2,
  output logic [3:0] min_1,
  output logic [2:0] min_2,
  output logic [3:0] hour_1,
  output logic [1:0] hour_2,
  output logic       time_strobe,
  output logic       fix_valid,
  output logic       parse_err
);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_R      = 8'h52;
  localparam logic [7:0] CH_M      = 8'h4D;
  localparam logic [7:0] CH_C      = 8'h43;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_V      = 8'h56;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_TIME, S_FRAC, S_STATUS, S_STATCOMMA, S_CKSKIP, S_CK_HI, S_CK_LO
  } state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [6:0]  byte_cnt;
  logic [3:0]  sh [6];
  logic        stat_a;

  logic        restart, abort, commit, cap, set_stat;
  logic        is_digit, too_long, range_ok, hdr_ok;
  logic [7:0]  hdr_char;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  // byte_cnt excludes the '$', so the incoming byte is number byte_cnt+2.
  assign too_long = byte_cnt >= 7'(MAX_LEN - 1);
  assign range_ok = (sh[0] <= 4'd2) && !((sh[0] == 4'd2) && (sh[1] > 4'd3)) &&
                    (sh[2] <= 4'd5) && (sh[4] <= 4'd5);

  always_comb begin
    case (idx)
      3'd2:    hdr_char = CH_R;
      3'd3:    hdr_char = CH_M;
      3'd4:    hdr_char = CH_C;
      default: hdr_char = CH_COMMA;
    endcase
  end
  assign hdr_ok = (idx < 3'd2) || (rx_data == hdr_char);

`ifdef NMEA_CHECKSUM_EN
  logic [7:0] ck_xor;
  logic [3:0] ck_hi;
  logic       hex_ok;
  logic [3:0] hex_val;
  logic       xor_en;

  always_comb begin
    hex_ok  = 1'b0;
    hex_val = rx_data[3:0];
    if (is_digit) begin
      hex_ok = 1'b1;
    end else if (((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                 ((rx_data >= 8'h61) && (rx_data <= 8'h66))) begin
      hex_ok  = 1'b1;
      hex_val = rx_data[3:0] + 4'd9;
    end
  end

  assign xor_en = (state inside {S_HDR, S_TIME, S_FRAC, S_STATUS, S_STATCOMMA, S_CKSKIP}) &&
                  (rx_data != 8'h2A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_xor <= '0;
      ck_hi  <= '0;
    end else if (rx_valid) begin
      if (restart) ck_xor <= '0;
      else if (xor_en) ck_xor <= ck_xor ^ rx_data;
      if (state == S_CK_HI) ck_hi <= hex_val;
    end
  end
`endif

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    restart  = 1'b0;
    abort    = 1'b0;
    commit   = 1'b0;
    cap      = 1'b0;
    set_stat = 1'b0;
    if (rx_valid) begin
      if (rx_data == CH_DOLLAR) begin
        restart = 1'b1;
        state_n = S_HDR;
        idx_n   = '0;
      end else if (state != S_IDLE && too_long) begin
        abort = 1'b1;
      end else begin
        case (state)
          S_IDLE: ;
          S_HDR: begin
            if (!hdr_ok) abort = 1'b1;
            else if (idx == 3'd5) begin
              state_n = S_TIME;
              idx_n   = '0;
            end else idx_n = idx + 3'd1;
          end
          S_TIME: begin
            if (!is_digit) abort = 1'b1;
            else begin
              cap = 1'b1;
              // The last seconds digit is unconstrained, so all tens checks are settled here.
              if (idx == 3'd5) begin
                if (range_ok) state_n = S_FRAC;
                else abort = 1'b1;
              end else idx_n = idx + 3'd1;
            end
          end
          S_FRAC: if (rx_data == CH_COMMA) state_n = S_STATUS;
          S_STATUS: begin
            if (rx_data == CH_A || rx_data == CH_V) begin
              set_stat = 1'b1;
              state_n  = S_STATCOMMA;
            end else abort = 1'b1;
          end
          S_STATCOMMA: begin
            if (rx_data != CH_COMMA) abort = 1'b1;
`ifdef NMEA_CHECKSUM_EN
            else state_n = S_CKSKIP;
`else
            else commit = 1'b1;
`endif
          end
`ifdef NMEA_CHECKSUM_EN
          S_CKSKIP: if (rx_data == 8'h2A) state_n = S_CK_HI;
          S_CK_HI: begin
            if (hex_ok) state_n = S_CK_LO;
            else abort = 1'b1;
          end
          S_CK_LO: begin
            if (hex_ok && ({ck_hi, hex_val} == ck_xor)) commit = 1'b1;
            else abort = 1'b1;
          end
`endif
          default: state_n = S_IDLE;
        endcase
      end
      if (abort || commit) state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      byte_cnt    <= '0;
      for (int i = 0; i < 6; i++) sh[i] <= '0;
      stat_a      <= 1'b0;
      sec_1       <= '0;
      sec_2       <= '0;
      min_1       <= '0;
      min_2       <= '0;
      hour_1      <= '0;
      hour_2      <= '0;
      fix_valid   <= 1'b0;
      time_strobe <= 1'b0;
      parse_err   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      time_strobe <= commit;
      parse_err   <= abort;
      if (rx_valid) begin
        if (restart) byte_cnt <= '0;
        else if (state != S_IDLE && byte_cnt != 7'h7F) byte_cnt <= byte_cnt + 7'd1;
      end
      if (cap) sh[idx] <= rx_data[3:0];
      if (set_stat) stat_a <= (rx_data == CH_A);
      if (commit) begin
        hour_2    <= sh[0][1:0];
        hour_1    <= sh[1];
        min_2     <= sh[2][2:0];
        min_1     <= sh[3];
        sec_2     <= sh[4][2:0];
        sec_1     <= sh[5];
        fix_valid <= stat_a;
      end
    end
  end

endmodule
